// File: rtl/uart_rx_frame_ctrl_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_rx_frame_ctrl_pkg
// Description : Shared state encoding, error codes and sync byte for the
//               UART receive framing controller.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_frame_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_CMD     = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4,
        ST_HOLD    = 3'd5
    } state_t;

    localparam logic [1:0] ERR_TIMEOUT = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CHK     = 2'd2;
    localparam logic [1:0] ERR_OVR     = 2'd3;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/uart_rx_frame_ctrl_frame_buf.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_rx_frame_ctrl_frame_buf
// Description : Payload buffer, synchronous write and combinational read.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_frame_ctrl_frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Addresses beyond the buffer depth read as zero.
    assign o_rdata = ({1'b0, i_raddr} < c_DEPTH) ? r_mem[i_raddr] : 8'h00;

endmodule
`default_nettype wire

// File: rtl/uart_rx_frame_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_rx_frame_ctrl
// Description : Sync hunt, header/payload parse, checksum check and frame
//               hold/release behind a UART receiver, with inter-byte timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_frame_ctrl
    import uart_rx_frame_ctrl_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE     = DEFAULT_SYNC_BYTE,
    parameter int         MAX_LEN       = 16,
    parameter int         AW            = 4,
    parameter int         LW            = 5,
    parameter int         TIMEOUT_TICKS = 640,
    parameter int         TW            = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_tick,
    input  logic          rx_done_tick,
    input  logic [7:0]    rx_data,
    output logic          frame_valid,
    output logic [7:0]    frame_cmd,
    output logic [LW-1:0] frame_len,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    input  logic          frame_ack,
    output logic          err_tick,
    output logic [1:0]    err_code,
    output logic          busy
);

    localparam logic [TW-1:0] c_TO_LAST  = TW'(TIMEOUT_TICKS - 1);
    localparam logic [8:0]    c_MAX_LEN  = 9'(MAX_LEN);

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_sum, w_sum_nxt;
    logic [7:0]    r_cmd, w_cmd_nxt;
    logic [LW-1:0] r_len, w_len_nxt;
    logic [AW-1:0] r_idx, w_idx_nxt;
    logic [TW-1:0] r_tcnt, w_tcnt_nxt;
    logic [1:0]    r_err_code, w_err_code_nxt;
    logic          r_err_tick, w_err;
    logic          w_we;
    logic          w_in_frame;

    assign w_in_frame = (r_state == ST_CMD) || (r_state == ST_LEN) ||
                        (r_state == ST_PAYLOAD) || (r_state == ST_CHK);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_sum_nxt      = r_sum;
        w_cmd_nxt      = r_cmd;
        w_len_nxt      = r_len;
        w_idx_nxt      = r_idx;
        w_tcnt_nxt     = r_tcnt;
        w_err_code_nxt = r_err_code;
        w_err          = 1'b0;
        w_we           = 1'b0;

        // A byte always beats a coincident terminal timeout tick.
        if (rx_done_tick) begin
            w_tcnt_nxt = '0;
            case (r_state)
                ST_HUNT: begin
                    if (rx_data == SYNC_BYTE) w_state_nxt = ST_CMD;
                end
                ST_CMD: begin
                    w_cmd_nxt   = rx_data;
                    w_sum_nxt   = rx_data;
                    w_state_nxt = ST_LEN;
                end
                ST_LEN: begin
                    w_sum_nxt = r_sum + rx_data;
                    if (rx_data == 8'h00) begin
                        w_len_nxt   = '0;
                        w_state_nxt = ST_CHK;
                    end else if ({1'b0, rx_data} > c_MAX_LEN) begin
                        w_err          = 1'b1;
                        w_err_code_nxt = ERR_LEN;
                        w_state_nxt    = ST_HUNT;
                    end else begin
                        w_len_nxt   = LW'(rx_data);
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    w_we      = 1'b1;
                    w_sum_nxt = r_sum + rx_data;
                    w_idx_nxt = r_idx + AW'(1);
                    if (LW'(r_idx) == (r_len - LW'(1))) w_state_nxt = ST_CHK;
                end
                ST_CHK: begin
                    if (rx_data == r_sum) begin
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_err          = 1'b1;
                        w_err_code_nxt = ERR_CHK;
                        w_state_nxt    = ST_HUNT;
                    end
                end
                ST_HOLD: begin
                    w_err          = 1'b1;
                    w_err_code_nxt = ERR_OVR;
                end
                default: w_state_nxt = ST_HUNT;
            endcase
        end else if (w_in_frame && s_tick) begin
            if (r_tcnt == c_TO_LAST) begin
                w_err          = 1'b1;
                w_err_code_nxt = ERR_TIMEOUT;
                w_state_nxt    = ST_HUNT;
            end else begin
                w_tcnt_nxt = r_tcnt + TW'(1);
            end
        end

        if ((r_state == ST_HOLD) && frame_ack) w_state_nxt = ST_HUNT;
        if (w_state_nxt == ST_HUNT) w_tcnt_nxt = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sum      <= '0;
            r_cmd      <= '0;
            r_len      <= '0;
            r_idx      <= '0;
            r_tcnt     <= '0;
            r_err_code <= ERR_TIMEOUT;
            r_err_tick <= 1'b0;
        end else begin
            r_sum      <= w_sum_nxt;
            r_cmd      <= w_cmd_nxt;
            r_len      <= w_len_nxt;
            r_idx      <= w_idx_nxt;
            r_tcnt     <= w_tcnt_nxt;
            r_err_code <= w_err_code_nxt;
            r_err_tick <= w_err;
        end
    end

    uart_rx_frame_ctrl_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_frame_buf (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_idx),
        .i_wdata (rx_data),
        .i_raddr (rd_addr),
        .o_rdata (rd_data)
    );

    assign frame_valid = (r_state == ST_HOLD);
    assign busy        = (r_state != ST_HUNT);
    assign frame_cmd   = r_cmd;
    assign frame_len   = r_len;
    assign err_tick    = r_err_tick;
    assign err_code    = r_err_code;

endmodule
`default_nettype wire
